// File: rtl/game_master_fsm_multi.sv
// Game master for one torpedo against N_TARGETS independent target sprites.
// Handshakes: there are no valid/ready pairs here. Every output is a Moore
// decode of the registered state and registers, so inputs only affect outputs
// one clock later. end_of_game_timer_start is a single-cycle request, and
// end_of_game_timer_running is a level that holds the game-over states.
module game_master_fsm_multi #(
    parameter int N_TARGETS = 2,
    parameter int N_SHOTS   = 3,
    parameter int SHOT_W    = 2,
    parameter int SCORE_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key,
    output logic [N_TARGETS-1:0] sprite_target_write_xy,
    output logic [N_TARGETS-1:0] sprite_target_write_dxy,
    output logic [N_TARGETS-1:0] sprite_target_enable_update,
    input  logic [N_TARGETS-1:0] sprite_target_within_screen,
    output logic                 sprite_torpedo_write_xy,
    output logic                 sprite_torpedo_write_dxy,
    output logic                 sprite_torpedo_enable_update,
    input  logic                 sprite_torpedo_within_screen,
    input  logic [N_TARGETS-1:0] collision,
    output logic                 end_of_game_timer_start,
    input  logic                 end_of_game_timer_running,
    output logic                 game_won,
    output logic                 game_lost,
    output logic [SCORE_W-1:0]   score,
    output logic [SHOT_W-1:0]    shots_left
);

    typedef enum logic [6:0] {
        START_ROUND     = 7'b0000001,
        WAIT_KEY        = 7'b0000010,
        FLY             = 7'b0000100,
        RELOAD          = 7'b0001000,
        START_END_TIMER = 7'b0010000,
        GAME_WON        = 7'b0100000,
        GAME_LOST       = 7'b1000000
    } state_t;

    localparam logic [N_TARGETS-1:0] ALL_TARGETS = {N_TARGETS{1'b1}};
    localparam logic [SHOT_W-1:0]    FULL_SHOTS  = SHOT_W'(N_SHOTS);

    state_t               state, state_next;
    logic [N_TARGETS-1:0] alive, alive_next;
    logic [SHOT_W-1:0]    shots_next;
    logic [SCORE_W-1:0]   score_next;
    logic                 key_prev;
    logic                 won_flag, won_flag_next;

    logic                 fire;
    logic [N_TARGETS-1:0] hit;
    logic                 target_gone;
    logic [SCORE_W:0]     hit_count;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

    // Fire edge, live hits, escaped live targets and the saturating score update
    always_comb begin
        fire        = key & ~key_prev;
        hit         = collision & alive;
        target_gone = |(alive & ~sprite_target_within_screen);
        hit_count   = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            hit_count = hit_count + {{SCORE_W{1'b0}}, hit[i]};
        end
        score_sum = {1'b0, score} + hit_count;
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Registers: state, alive mask, shot budget, score, key history, round result
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= START_ROUND;
            alive      <= ALL_TARGETS;
            shots_left <= FULL_SHOTS;
            score      <= '0;
            key_prev   <= 1'b0;
            won_flag   <= 1'b0;
        end else begin
            state      <= state_next;
            alive      <= alive_next;
            shots_left <= shots_next;
            score      <= score_next;
            key_prev   <= key;
            won_flag   <= won_flag_next;
        end
    end

    // Next-state, register updates and Moore output decode
    always_comb begin
        state_next                   = state;
        alive_next                   = alive;
        shots_next                   = shots_left;
        score_next                   = score;
        won_flag_next                = won_flag;
        sprite_target_write_xy       = '0;
        sprite_target_write_dxy      = '0;
        sprite_target_enable_update  = '0;
        sprite_torpedo_write_xy      = 1'b0;
        sprite_torpedo_write_dxy     = 1'b0;
        sprite_torpedo_enable_update = 1'b0;
        end_of_game_timer_start      = 1'b0;
        game_won                     = 1'b0;
        game_lost                    = 1'b0;

        case (state)
            START_ROUND: begin
                // Every target is reloaded here, including those killed last round
                sprite_target_write_xy  = ALL_TARGETS;
                sprite_target_write_dxy = ALL_TARGETS;
                sprite_torpedo_write_xy = 1'b1;
                alive_next              = ALL_TARGETS;
                shots_next              = FULL_SHOTS;
                if (!won_flag) begin
                    score_next = '0;
                end
                state_next = WAIT_KEY;
            end
            WAIT_KEY: begin
                sprite_target_enable_update = alive;
                sprite_torpedo_write_dxy    = 1'b1;
                if (target_gone) begin
                    won_flag_next = 1'b0;
                    state_next    = START_END_TIMER;
                end else if (fire) begin
                    shots_next = shots_left - SHOT_W'(1);
                    state_next = FLY;
                end
            end
            FLY: begin
                sprite_target_enable_update  = alive;
                sprite_torpedo_enable_update = 1'b1;
                if (hit != '0) begin
                    alive_next = alive & ~hit;
                    score_next = score_sat;
                    state_next = RELOAD;
                end else if (!sprite_torpedo_within_screen) begin
                    state_next = RELOAD;
                end else if (target_gone) begin
                    won_flag_next = 1'b0;
                    state_next    = START_END_TIMER;
                end
            end
            RELOAD: begin
                sprite_torpedo_write_xy = 1'b1;
                if (alive == '0) begin
                    won_flag_next = 1'b1;
                    state_next    = START_END_TIMER;
                end else if (shots_left == '0) begin
                    won_flag_next = 1'b0;
                    state_next    = START_END_TIMER;
                end else begin
                    state_next = WAIT_KEY;
                end
            end
            START_END_TIMER: begin
                end_of_game_timer_start = 1'b1;
                state_next              = won_flag ? GAME_WON : GAME_LOST;
            end
            GAME_WON: begin
                game_won = 1'b1;
                if (!end_of_game_timer_running) begin
                    state_next = START_ROUND;
                end
            end
            GAME_LOST: begin
                game_lost = 1'b1;
                if (!end_of_game_timer_running) begin
                    state_next = START_ROUND;
                end
            end
            default: begin
                // Corrupted one-hot encoding: restart cleanly
                state_next = START_ROUND;
            end
        endcase
    end

endmodule

// File: tb/tb_game_master_fsm_multi.sv
// Bench for game_master_fsm_multi: scripted rounds plus randomised winning
// rounds, with a round-result scoreboard popped on game-over entry.
module tb_game_master_fsm_multi;
  localparam int NT  = 2;
  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int SCW = 8;
  localparam int RW  = 2 + SCW + SW;
  localparam logic [NT-1:0] ALL_T = {NT{1'b1}};

  logic           clk = 1'b0;
  logic           reset;
  logic           key;
  logic [NT-1:0]  t_wxy, t_wdxy, t_en, t_ws;
  logic           torp_wxy, torp_wdxy, torp_en, torp_ws;
  logic [NT-1:0]  collision;
  logic           timer_start, timer_running;
  logic           game_won, game_lost;
  logic [SCW-1:0] score;
  logic [SW-1:0]  shots_left;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  game_master_fsm_multi #(
    .N_TARGETS(NT), .N_SHOTS(NS), .SHOT_W(SW), .SCORE_W(SCW)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .key                          (key),
    .sprite_target_write_xy       (t_wxy),
    .sprite_target_write_dxy      (t_wdxy),
    .sprite_target_enable_update  (t_en),
    .sprite_target_within_screen  (t_ws),
    .sprite_torpedo_write_xy      (torp_wxy),
    .sprite_torpedo_write_dxy     (torp_wdxy),
    .sprite_torpedo_enable_update (torp_en),
    .sprite_torpedo_within_screen (torp_ws),
    .collision                    (collision),
    .end_of_game_timer_start      (timer_start),
    .end_of_game_timer_running    (timer_running),
    .game_won                     (game_won),
    .game_lost                    (game_lost),
    .score                        (score),
    .shots_left                   (shots_left)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- model ----------------
  logic [RW-1:0] exp_q[$];
  logic [NT-1:0] m_alive;
  int            m_shots;
  int            m_score;
  bit            m_lost;
  bit            hold_key;
  bit            started;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT sits in START_ROUND: check the load strobes, step into WAIT_KEY
  task automatic start_round_checks();
    check_eq("sr_target_wxy", t_wxy, ALL_T);
    check_eq("sr_target_wdxy", t_wdxy, ALL_T);
    check_eq("sr_torp_wxy", torp_wxy, 1);
    tick();
    m_alive = ALL_T;
    m_shots = NS;
    if (m_lost) m_score = 0;
    check_eq("wk_torp_wdxy", torp_wdxy, 1);
    check_eq("wk_target_en", t_en, m_alive);
    check_eq("wk_score", score, m_score);
    check_eq("wk_shots", shots_left, m_shots);
  endtask

  // Next clock enters START_END_TIMER; run the game-over phase through to WAIT_KEY
  task automatic finish_game(input bit won);
    int n;
    exp_q.push_back({won, ~won, m_score[SCW-1:0], m_shots[SW-1:0]});
    tick();
    key = 1'b0; t_ws = ALL_T; collision = '0; torp_ws = 1'b1;
    check_eq("timer_start", timer_start, 1);
    timer_running = 1'b1;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      tick();
      if (hold_key) key = 1'b1;
      check_eq("ts_pulse_width", timer_start, 0);
      check_eq("go_won", game_won, won);
      check_eq("go_lost", game_lost, !won);
      check_eq("go_torp_en", torp_en, 0);
      check_eq("go_target_en", t_en, 0);
    end
    m_lost = !won;
    timer_running = 1'b0;
    tick();
    start_round_checks();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_fire();
    key = 1'b1;
    tick();
    key = 1'b0;
    m_shots--;
    check_eq("fire_shots", shots_left, m_shots);
    check_eq("fire_in_fly", torp_en, 1);
  endtask

  // One FLY cycle with the given collision / torpedo / target screen inputs
  task automatic fly_step(input logic [NT-1:0] coll, input logic torp_in, input logic [NT-1:0] tgt);
    logic [NT-1:0] h;
    int pc;
    bit left;
    collision = coll; torp_ws = torp_in; t_ws = tgt;
    h = coll & m_alive;
    if (h == '0 && torp_in && (m_alive & ~tgt) != '0) begin
      finish_game(1'b0);
      return;
    end
    tick();
    collision = '0; torp_ws = 1'b1; t_ws = ALL_T;
    left = 1'b0;
    if (h != '0) begin
      pc = 0;
      for (int i = 0; i < NT; i++) pc += int'(h[i]);
      m_alive = m_alive & ~h;
      m_score = (m_score + pc > 255) ? 255 : m_score + pc;
      left = 1'b1;
    end else if (!torp_in) begin
      left = 1'b1;
    end
    check_eq("fly_score", score, m_score);
    if (!left) begin
      check_eq("still_fly", torp_en, 1);
      return;
    end
    check_eq("reload_torp_wxy", torp_wxy, 1);
    check_eq("reload_target_wxy", t_wxy, 0);
    if (m_alive == '0) finish_game(1'b1);
    else if (m_shots == 0) finish_game(1'b0);
    else begin
      tick();
      check_eq("back_to_wait", torp_wdxy, 1);
      check_eq("wait_target_en", t_en, m_alive);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          prev_res = 1'b0;
  logic [RW-1:0] mon_exp;

  always @(negedge clk) begin
    if (started && !reset) begin
      if ((game_won | game_lost) && !prev_res) begin
        if (exp_q.size() == 0) check_eq("unexpected_result", 1, 0);
        else begin
          mon_exp = exp_q.pop_front();
          check_eq("round_result", {game_won, game_lost, score, shots_left}, mon_exp);
        end
      end
      prev_res = game_won | game_lost;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; key = 1'b0; t_ws = ALL_T; torp_ws = 1'b1;
    collision = '0; timer_running = 1'b0;
    hold_key = 1'b0; m_lost = 1'b0; m_score = 0; started = 1'b0;
    tick(); tick();
    check_eq("rst_score", score, 0);
    check_eq("rst_shots", shots_left, NS);
    check_eq("rst_won", game_won, 0);
    check_eq("rst_lost", game_lost, 0);
    check_eq("rst_target_wdxy", t_wdxy, ALL_T);
    reset = 1'b0;
    started = 1'b1;
    start_round_checks();

    // Two single hits win the round; score carries into the next round
    do_fire(); fly_step(2'b01, 1'b1, ALL_T);
    do_fire(); fly_step(2'b10, 1'b1, ALL_T);

    // Three misses lose the round; score clears on the following round
    do_fire(); fly_step(2'b00, 1'b0, ALL_T);
    do_fire(); fly_step(2'b00, 1'b0, ALL_T);
    do_fire(); fly_step(2'b00, 1'b0, ALL_T);

    // Double hit in the same cycle as the torpedo leaving: hit wins
    do_fire(); fly_step(2'b11, 1'b0, ALL_T);

    // Target escape together with a fire edge in WAIT_KEY: loss, shots unchanged
    key = 1'b1; t_ws = 2'b01;
    finish_game(1'b0);

    // Collision with a dead target is ignored; then miss and finish it off
    do_fire(); fly_step(2'b01, 1'b1, ALL_T);
    do_fire(); fly_step(2'b01, 1'b1, ALL_T);
    fly_step(2'b00, 1'b0, ALL_T);
    do_fire(); fly_step(2'b10, 1'b1, ALL_T);

    // Live target escaping during FLY loses the round
    do_fire(); fly_step(2'b00, 1'b1, 2'b10);

    // Key held high through game-over and round start must not fire
    do_fire(); fly_step(2'b11, 1'b1, ALL_T);
    hold_key = 1'b1;
    do_fire(); fly_step(2'b11, 1'b1, ALL_T);
    hold_key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("held_key_no_fire", torp_wdxy, 1);
      check_eq("held_key_shots", shots_left, NS);
    end
    key = 1'b0;
    tick();

    // Randomised winning rounds drive the score into saturation
    for (int it = 0; it < 200 && m_score < 255; it++) begin
      case ($urandom_range(0, 2))
        0: begin do_fire(); fly_step(2'b11, 1'b1, ALL_T); end
        1: begin
          do_fire(); fly_step(2'b01, 1'b1, ALL_T);
          do_fire(); fly_step(2'b10, 1'b1, ALL_T);
        end
        default: begin
          do_fire(); fly_step(2'b00, 1'b0, ALL_T);
          do_fire(); fly_step(2'b10, 1'b1, ALL_T);
          do_fire(); fly_step(2'b01, 1'b1, ALL_T);
        end
      endcase
    end
    check_eq("score_reached_max", score, 255);
    do_fire(); fly_step(2'b11, 1'b1, ALL_T);
    check_eq("score_saturated", score, 255);

    // Reset in FLY aborts the round
    do_fire();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_score", score, 0);
    check_eq("midrst_shots", shots_left, NS);
    check_eq("midrst_torp_en", torp_en, 0);
    m_score = 0; m_lost = 1'b0;
    start_round_checks();

    tick();
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
